// File: rtl/exit_status_reporter_pkg.sv
// Shared types and constants for the exit status reporter: UART bit FSM
// states, message length, fixed message bytes and nibble-to-ASCII helper.
package exit_status_reporter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  localparam int         MSG_LEN  = 15;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_T  = 8'h54;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nibble2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/exit_status_reporter_uart_tx.sv
// One-byte 8N1 UART serializer. ready_o is high while idle and during the
// last cycle of the stop bit, so a byte offered back-to-back starts its
// start bit immediately after the previous stop bit with no idle gap.
module uart_tx_byte
  import exit_status_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 130
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_e            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);
  assign ready_o = (state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end);
  assign tx_o    = tx_q;

  // Bit-level FSM: baud counter, bit index, shifter and registered TX line.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else if (ready_o && valid_i) begin
      state_q <= ST_START;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= data_i;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exit_status_reporter.sv
// Captures the exit code on a rising edge of exit_valid_i and sends
// "EXIT=XXXXXXXX\r\n" over UART, keeping sticky done/pass flags for LEDs.
module exit_status_reporter
  import exit_status_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 130
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o
);

  logic        valid_q, valid_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic        rise, start, char_end;
  logic        send_valid, send_ready;
  logic [7:0]  send_data;

  // Message byte at position idx; hex digits come MSB first from val.
  function automatic logic [7:0] char_at(input logic [3:0] idx, input logic [31:0] val);
    logic [3:0] nib;
    case (idx)
      4'd0:    return CH_E;
      4'd1:    return CH_X;
      4'd2:    return CH_I;
      4'd3:    return CH_T;
      4'd4:    return CH_EQ;
      4'd13:   return CH_CR;
      4'd14:   return CH_LF;
      default: begin
        nib = 4'(val >> {4'd12 - idx, 2'b00});
        return nibble2ascii(nib);
      end
    endcase
  endfunction

  // Rise detection, char sequencing and status next-state. Char 0 is offered
  // directly on the capture edge so its start bit begins on that same edge.
  always_comb begin
    rise       = exit_valid_i & ~valid_q;
    start      = rise & ~busy_q;
    char_end   = busy_q & send_ready;
    send_valid = busy_q ? (char_idx_q != LAST_IDX) : start;
    send_data  = busy_q ? char_at(char_idx_q + 4'd1, value_q) : CH_E;

    valid_d    = exit_valid_i;
    value_d    = value_q;
    char_idx_d = char_idx_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;

    if (start) begin
      value_d    = exit_value_i;
      pass_d     = (exit_value_i == 32'd0);
      done_d     = 1'b0;
      busy_d     = 1'b1;
      char_idx_d = 4'd0;
    end else if (char_end) begin
      if (char_idx_q == LAST_IDX) begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        char_idx_d = 4'd0;
      end else begin
        char_idx_d = char_idx_q + 4'd1;
      end
    end
  end

  // Capture and status registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      value_q    <= '0;
      char_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      value_q    <= value_d;
      char_idx_q <= char_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (send_data),
    .valid_i(send_valid),
    .ready_o(send_ready),
    .tx_o   (tx_o)
  );

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;

endmodule

// File: tb/tb_exit_status_reporter.sv
// Bench for exit_status_reporter at 4 clocks per bit, with a UART receiver
// and a string-level model of the expected report.
module tb_exit_status_reporter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        tx_o, busy_o, done_o, pass_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] rxq[$];
  int         mon_ferr = 0;

  always #5 clk = ~clk;

  exit_status_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o)
  );

  // UART receiver sampling mid-bit on falling clock edges; reset abandons a frame.
  initial begin
    bit         active = 0;
    int         cnt = 0;
    logic [7:0] sh = '0;
    forever begin
      @(negedge clk);
      if (rst_ni !== 1'b1) begin
        active = 0;
      end else if (!active) begin
        if (tx_o === 1'b0) begin
          active = 1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt == 1) begin
          if (tx_o !== 1'b0) begin
            mon_ferr++;
            active = 0;
          end
        end else if (cnt >= 1 + CPB && cnt <= 1 + 8 * CPB && ((cnt - 1) % CPB) == 0) begin
          sh[(cnt - 1) / CPB - 1] = tx_o;
        end else if (cnt == 1 + 9 * CPB) begin
          if (tx_o !== 1'b1) mon_ferr++;
          else rxq.push_back(sh);
          active = 0;
        end
      end
    end
  end

  // Expected report text for an exit code.
  function automatic string model_msg(input logic [31:0] v);
    string hexd = "0123456789ABCDEF";
    string s = "EXIT=";
    for (int i = 0; i < 8; i++) begin
      int n = int'((v >> (28 - 4 * i)) & 32'hF);
      s = {s, hexd.substr(n, n)};
    end
    return {s, "\r\n"};
  endfunction

  // Raise exit_valid with value v (optionally releasing reset on the same
  // cycle), optionally injecting a second rise at cycle glitch_at, and
  // measure busy length, initial low run on tx and done right after capture.
  task automatic run_msg(input logic [31:0] v, input bit rel, input int glitch_at,
                         input logic [31:0] gv, output int cyc, output int lowlen,
                         output logic done1);
    @(negedge clk);
    exit_value_i = v;
    exit_valid_i = 1'b1;
    if (rel) rst_ni = 1'b1;
    cyc    = 0;
    lowlen = 0;
    done1  = 1'bx;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge clk);
      if (t == 1) done1 = done_o;
      if (glitch_at > 0 && t == glitch_at - 10) exit_valid_i = 1'b0;
      if (glitch_at > 0 && t == glitch_at) begin
        exit_value_i = gv;
        exit_valid_i = 1'b1;
      end
      if (tx_o === 1'b0 && lowlen == t - 1) lowlen++;
      if (busy_o === 1'b1) cyc++;
      else break;
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    exit_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rxq.delete();
    mon_ferr = 0;
  endtask

  task automatic test_reset();
    rst_ni       = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_outs cyc=%0d got tx=%b busy=%b done=%b pass=%b want 1000",
                 c, tx_o, busy_o, done_o, pass_o);
      end
      exit_valid_i = 1'($urandom);
      exit_value_i = $urandom;
    end
    exit_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got tx=%b busy=%b want tx=1 busy=0", tx_o, busy_o);
    end
    rxq.delete();
  endtask

  task automatic test_pass();
    int cyc, lowlen;
    logic d1;
    string exp = model_msg(32'd0);
    run_msg(32'd0, 0, 0, 0, cyc, lowlen, d1);
    checks++;
    if (cyc != 150 * CPB) begin
      errors++;
      $display("FAIL pass_busy_len got=%0d want=%0d", cyc, 150 * CPB);
    end
    checks++;
    if (rxq.size() != exp.len() || mon_ferr != 0) begin
      errors++;
      $display("FAIL pass_msg_len got=%0d ferr=%0d want=%0d", rxq.size(), mon_ferr, exp.len());
    end
    for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
      checks++;
      if (rxq[i] !== exp[i]) begin
        errors++;
        $display("FAIL pass_char%0d got=%h want=%h", i, rxq[i], exp[i]);
      end
    end
    checks++;
    if (done_o !== 1'b1 || pass_o !== 1'b1) begin
      errors++;
      $display("FAIL pass_status got done=%b pass=%b want 11", done_o, pass_o);
    end
    idle_gap();
  endtask

  task automatic test_fail();
    int cyc, lowlen;
    logic d1;
    string exp = model_msg(32'hDEADBEEF);
    run_msg(32'hDEADBEEF, 0, 0, 0, cyc, lowlen, d1);
    checks++;
    if (lowlen != CPB) begin
      errors++;
      $display("FAIL fail_startbit_width got=%0d want=%0d", lowlen, CPB);
    end
    checks++;
    if (rxq.size() != exp.len() || mon_ferr != 0) begin
      errors++;
      $display("FAIL fail_msg_len got=%0d ferr=%0d want=%0d", rxq.size(), mon_ferr, exp.len());
    end
    for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
      checks++;
      if (rxq[i] !== exp[i]) begin
        errors++;
        $display("FAIL fail_char%0d got=%h want=%h", i, rxq[i], exp[i]);
      end
    end
    checks++;
    if (done_o !== 1'b1 || pass_o !== 1'b0) begin
      errors++;
      $display("FAIL fail_status got done=%b pass=%b want 10", done_o, pass_o);
    end
    idle_gap();
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int cyc, lowlen;
      logic d1;
      logic [31:0] v = $urandom;
      string exp;
      if (r == 0) v[3:0] = 4'hA;
      exp = model_msg(v);
      run_msg(v, 0, 0, 0, cyc, lowlen, d1);
      checks++;
      if (cyc != 150 * CPB || rxq.size() != exp.len() || mon_ferr != 0) begin
        errors++;
        $display("FAIL rand%0d_frame v=%h got busy=%0d chars=%0d ferr=%0d want busy=%0d chars=%0d",
                 r, v, cyc, rxq.size(), mon_ferr, 150 * CPB, exp.len());
      end
      for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
        checks++;
        if (rxq[i] !== exp[i]) begin
          errors++;
          $display("FAIL rand%0d_char%0d got=%h want=%h", r, i, rxq[i], exp[i]);
        end
      end
      checks++;
      if (done_o !== 1'b1 || pass_o !== (v == 32'd0)) begin
        errors++;
        $display("FAIL rand%0d_status got done=%b pass=%b want done=1 pass=%b", r, done_o, pass_o, v == 0);
      end
      idle_gap();
    end
  endtask

  task automatic test_collision();
    int cyc, lowlen;
    logic d1;
    logic [31:0] v1 = $urandom | 32'h1000_0000;
    string exp = model_msg(v1);
    run_msg(v1, 0, 100, 32'd1, cyc, lowlen, d1);
    checks++;
    if (cyc != 150 * CPB || rxq.size() != exp.len() || mon_ferr != 0) begin
      errors++;
      $display("FAIL coll_frame got busy=%0d chars=%0d ferr=%0d want busy=%0d chars=%0d",
               cyc, rxq.size(), mon_ferr, 150 * CPB, exp.len());
    end
    for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
      checks++;
      if (rxq[i] !== exp[i]) begin
        errors++;
        $display("FAIL coll_char%0d got=%h want=%h", i, rxq[i], exp[i]);
      end
    end
    idle_gap();
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL retrig_done_before got=%b want=1", done_o);
    end
    exp = model_msg(32'd1);
    run_msg(32'd1, 0, 0, 0, cyc, lowlen, d1);
    checks++;
    if (d1 !== 1'b0) begin
      errors++;
      $display("FAIL retrig_done_drop got=%b want=0", d1);
    end
    checks++;
    if (rxq.size() != exp.len() || mon_ferr != 0) begin
      errors++;
      $display("FAIL retrig_msg_len got=%0d ferr=%0d want=%0d", rxq.size(), mon_ferr, exp.len());
    end
    for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
      checks++;
      if (rxq[i] !== exp[i]) begin
        errors++;
        $display("FAIL retrig_char%0d got=%h want=%h", i, rxq[i], exp[i]);
      end
    end
    checks++;
    if (done_o !== 1'b1 || pass_o !== 1'b0) begin
      errors++;
      $display("FAIL retrig_status got done=%b pass=%b want 10", done_o, pass_o);
    end
    idle_gap();
  endtask

  task automatic test_level_held();
    int cyc, lowlen, hi_bad;
    logic d1;
    string exp = model_msg(32'h0000_00A5);
    @(negedge clk);
    rst_ni       = 1'b0;
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_00A5;
    repeat (3) @(negedge clk);
    rxq.delete();
    run_msg(32'h0000_00A5, 1, 0, 0, cyc, lowlen, d1);
    checks++;
    if (cyc != 150 * CPB || rxq.size() != exp.len() || mon_ferr != 0) begin
      errors++;
      $display("FAIL level_frame got busy=%0d chars=%0d ferr=%0d want busy=%0d chars=%0d",
               cyc, rxq.size(), mon_ferr, 150 * CPB, exp.len());
    end
    for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
      checks++;
      if (rxq[i] !== exp[i]) begin
        errors++;
        $display("FAIL level_char%0d got=%h want=%h", i, rxq[i], exp[i]);
      end
    end
    hi_bad = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) hi_bad++;
    end
    checks++;
    if (hi_bad != 0 || rxq.size() != exp.len()) begin
      errors++;
      $display("FAIL level_single_report got bad_cycles=%0d chars=%0d want 0 and %0d",
               hi_bad, rxq.size(), exp.len());
    end
    idle_gap();
  endtask

  task automatic test_mid_reset();
    int cyc, lowlen;
    logic d1;
    logic [31:0] v1 = $urandom;
    logic [31:0] v2 = $urandom;
    string exp = model_msg(v2);
    @(negedge clk);
    exit_value_i = v1;
    exit_valid_i = 1'b1;
    repeat (250) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort got tx=%b busy=%b want tx=1 busy=0", tx_o, busy_o);
    end
    repeat (4) @(negedge clk);
    rxq.delete();
    mon_ferr = 0;
    run_msg(v2, 1, 0, 0, cyc, lowlen, d1);
    checks++;
    if (cyc != 150 * CPB || rxq.size() != exp.len() || mon_ferr != 0) begin
      errors++;
      $display("FAIL midrst_frame got busy=%0d chars=%0d ferr=%0d want busy=%0d chars=%0d",
               cyc, rxq.size(), mon_ferr, 150 * CPB, exp.len());
    end
    for (int i = 0; i < rxq.size() && i < exp.len(); i++) begin
      checks++;
      if (rxq[i] !== exp[i]) begin
        errors++;
        $display("FAIL midrst_char%0d got=%h want=%h", i, rxq[i], exp[i]);
      end
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_random();
    test_collision();
    test_level_held();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
